seg_scan_ctrl: RTL

//   Time-multiplexed scan controller for a bank of common-anode 7-segment digits.

---
 rtl/seg_scan_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Function : Time-multiplexed scan controller for common-anode 7-segment
//            digits. Walks the digit strobes through GUARD/DISPLAY slots,
//            drives the digit code and brightness gate to the shared decoder,
//            and double-buffers digit values so a frame never tears.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int DIGIT_TICKS = 1000,
  parameter int GUARD_TICKS = 8,
  parameter int PWM_BITS    = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic [PWM_BITS-1:0]     bright_i,
  input  logic                    load_valid_i,
  output logic                    load_ready_o,
  input  logic [4*NUM_DIGITS-1:0] load_data_i,
  output logic [3:0]              out_o,
  output logic                    pwm_act_o,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic                    frame_done_o
);

  localparam int TICK_MAX = (DIGIT_TICKS > GUARD_TICKS) ? DIGIT_TICKS : GUARD_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW       = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GUARD = 2'd1,
    S_DISP  = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  logic [PWM_BITS-1:0] bright_q, bright_d;
  logic [DW-1:0]       active_q, active_d;
  logic [DW-1:0]       pending_q, pending_d;
  logic                pend_flag_q, pend_flag_d;
  logic                wrap;
  logic                xfer;
  logic                commit;

  // Output registers are loaded from next-state values so they line up
  // with the state they describe.
  logic [3:0]            out_q, out_d;
  logic                  pwm_act_q, pwm_act_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic                  load_ready_q, load_ready_d;

  // Scan sequencer: slot timing, digit index and PWM phase.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    tick_d   = tick_q;
    pwm_d    = pwm_q;
    bright_d = bright_q;
    wrap     = 1'b0;
    if (!en_i) begin
      state_d = S_IDLE;
      idx_d   = '0;
      tick_d  = '0;
      pwm_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_GUARD;
          idx_d   = '0;
          tick_d  = '0;
        end
        S_GUARD: begin
          if (tick_q == TW'(GUARD_TICKS - 1)) begin
            state_d  = S_DISP;
            tick_d   = '0;
            pwm_d    = '0;
            bright_d = bright_i;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_DISP: begin
          pwm_d = pwm_q + PWM_BITS'(1);
          if (tick_q == TW'(DIGIT_TICKS - 1)) begin
            state_d = S_GUARD;
            tick_d  = '0;
            if (idx_q == IW'(NUM_DIGITS - 1)) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + IW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          idx_d   = '0;
          tick_d  = '0;
          pwm_d   = '0;
        end
      endcase
    end
  end

  // Load buffer: accept into pending, promote to active only at a frame
  // wrap (or straight away while idle, where nothing is on display).
  always_comb begin
    xfer        = load_valid_i & load_ready_q;
    commit      = pend_flag_q & (wrap | (state_q == S_IDLE));
    active_d    = commit ? pending_q : active_q;
    pending_d   = xfer ? load_data_i : pending_q;
    pend_flag_d = pend_flag_q;
    if (commit) pend_flag_d = 1'b0;
    if (xfer)   pend_flag_d = 1'b1;
    load_ready_d = ~pend_flag_d;
  end

  // Decoder-facing outputs derived from the upcoming state.
  always_comb begin
    out_d        = 4'hF;
    an_d         = '1;
    pwm_act_d    = 1'b0;
    frame_done_d = wrap;
    if (state_d != S_IDLE) begin
      out_d = active_d[{idx_d, 2'b00} +: 4];
    end
    if (state_d == S_DISP) begin
      an_d      = ~(NUM_DIGITS'(1) << idx_d);
      pwm_act_d = (pwm_d < bright_d);
    end
  end

  // State, buffer and output registers; reset blanks immediately.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      tick_q       <= '0;
      pwm_q        <= '0;
      bright_q     <= '0;
      active_q     <= '1;
      pending_q    <= '1;
      pend_flag_q  <= 1'b0;
      out_q        <= 4'hF;
      pwm_act_q    <= 1'b0;
      an_q         <= '1;
      frame_done_q <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      tick_q       <= tick_d;
      pwm_q        <= pwm_d;
      bright_q     <= bright_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      pend_flag_q  <= pend_flag_d;
      out_q        <= out_d;
      pwm_act_q    <= pwm_act_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
      load_ready_q <= load_ready_d;
    end
  end

  assign out_o        = out_q;
  assign pwm_act_o    = pwm_act_q;
  assign an_o         = an_q;
  assign frame_done_o = frame_done_q;
  assign load_ready_o = load_ready_q;

endmodule
`default_nettype wire
